rx_serial_7e1: RTL

//  Asynchronous serial receiver for 7E1 frames: start, 7 data bits LSB first, even parity, 1 stop bit.

---
 rtl/rx_serial_7e1_pkg.sv | 23 ++
 rtl/rx_serial_7e1_fd.sv | 126 ++++++++++++
 rtl/rx_serial_7e1_uc.sv | 91 +++++++++
 rtl/rx_serial_7e1.sv | 76 +++++++
 4 files changed

// File: rtl/rx_serial_7e1_pkg.sv
// Shared definitions for the 7E1 serial link: FSM state codes (also used by
// the HEX debug display), standard bit-period values and frame geometry.
package rx_serial_7e1_pkg;

  localparam int unsigned CLKS_115200 = 434;
  localparam int unsigned CLKS_9600   = 5208;
  localparam int unsigned DATA_BITS   = 7;
  // Data bits plus parity plus stop, all shifted into one register.
  localparam int unsigned FRAME_BITS  = DATA_BITS + 2;

  localparam logic [3:0] INICIAL    = 4'd0;
  localparam logic [3:0] START_MEIO = 4'd1;
  localparam logic [3:0] DADOS      = 4'd2;
  localparam logic [3:0] PARIDADE   = 4'd3;
  localparam logic [3:0] STOP       = 4'd4;
  localparam logic [3:0] ARMAZENA   = 4'd5;

  // 1 when the total number of ones (data + parity) is odd.
  function automatic logic paridade_impar(input logic [DATA_BITS:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/rx_serial_7e1_fd.sv
// Datapath of the 7E1 receiver: RX synchronizer, bit-timing counter, frame
// shift register, bit index, holding register and status flags.
// Ports:
//   clock, reset (async, active-low)
//   entrada_serial  raw RX line        recebe_dado  consumer acknowledge
//   zera/conta/desloca/registra        controls from the FSM
//   rx_s            synchronized line  armado       line seen idle since last store
//   fim_meio/fim_bit half/full bit terminal counts
//   ultimo_dado     shifting the last data bit
//   dados_ascii, tem_dado, pronto, erro_paridade, erro_stop, erro_overrun
module rx_serial_7e1_fd
  import rx_serial_7e1_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_115200,
  parameter int unsigned CNT_W        = 13
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       entrada_serial,
  input  logic       recebe_dado,
  input  logic       zera,
  input  logic       conta,
  input  logic       desloca,
  input  logic       registra,
  output logic       rx_s,
  output logic       armado,
  output logic       fim_meio,
  output logic       fim_bit,
  output logic       ultimo_dado,
  output logic [6:0] dados_ascii,
  output logic       tem_dado,
  output logic       pronto,
  output logic       erro_paridade,
  output logic       erro_stop,
  output logic       erro_overrun
);

  localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_TC = CNT_W'(CLKS_PER_BIT - 1);

  logic                  sync1;
  logic [CNT_W-1:0]      cnt;
  logic [3:0]            idx;
  logic [FRAME_BITS-1:0] sr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= entrada_serial;
      rx_s  <= sync1;
    end
  end

  assign fim_meio    = (cnt == HALF_TC);
  assign fim_bit     = (cnt == FULL_TC);
  assign ultimo_dado = (idx == 4'(DATA_BITS - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (zera) begin
      cnt <= '0;
    end else if (conta) begin
      cnt <= fim_bit ? '0 : cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx <= '0;
    end else if (zera) begin
      idx <= '0;
    end else if (desloca) begin
      idx <= idx + 1'b1;
    end
  end

  // LSB-first: after 9 shifts sr = {stop, parity, data[6:0]}.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sr <= '0;
    end else if (desloca) begin
      sr <= {rx_s, sr[FRAME_BITS-1:1]};
    end
  end

  // Blocks start detection after a store until the line has been seen high,
  // so a held break does not produce repeated frames.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      armado <= 1'b1;
    end else if (registra) begin
      armado <= rx_s;
    end else if (rx_s) begin
      armado <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dados_ascii   <= '0;
      tem_dado      <= 1'b0;
      pronto        <= 1'b0;
      erro_paridade <= 1'b0;
      erro_stop     <= 1'b0;
      erro_overrun  <= 1'b0;
    end else begin
      pronto <= registra;
      if (registra) begin
        dados_ascii   <= sr[DATA_BITS-1:0];
        erro_paridade <= paridade_impar(sr[DATA_BITS:0]);
        erro_stop     <= ~sr[FRAME_BITS-1];
        tem_dado      <= 1'b1;
        if (tem_dado && !recebe_dado) begin
          erro_overrun <= 1'b1;
        end
      end else if (recebe_dado) begin
        tem_dado     <= 1'b0;
        erro_overrun <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/rx_serial_7e1_uc.sv
// Control unit of the 7E1 receiver.
// Ports:
//   clock, reset (async, active-low)
//   rx_s, armado, fim_meio, fim_bit, ultimo_dado   status from the datapath
//   zera, conta, desloca, registra                 datapath controls
//   db_tick   sample strobe    db_estado  current state code
module rx_serial_7e1_uc
  import rx_serial_7e1_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_s,
  input  logic       armado,
  input  logic       fim_meio,
  input  logic       fim_bit,
  input  logic       ultimo_dado,
  output logic       zera,
  output logic       conta,
  output logic       desloca,
  output logic       registra,
  output logic       db_tick,
  output logic [3:0] db_estado
);

  logic [3:0] estado;
  logic [3:0] proximo;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado <= INICIAL;
    end else begin
      estado <= proximo;
    end
  end

  always_comb begin
    proximo  = estado;
    zera     = 1'b0;
    conta    = 1'b0;
    desloca  = 1'b0;
    registra = 1'b0;
    db_tick  = 1'b0;
    case (estado)
      INICIAL: begin
        zera = 1'b1;
        if (!rx_s && armado) proximo = START_MEIO;
      end
      START_MEIO: begin
        conta = 1'b1;
        if (fim_meio) begin
          db_tick = 1'b1;
          zera    = 1'b1;
          proximo = rx_s ? INICIAL : DADOS;
        end
      end
      DADOS: begin
        conta = 1'b1;
        if (fim_bit) begin
          db_tick = 1'b1;
          desloca = 1'b1;
          if (ultimo_dado) proximo = PARIDADE;
        end
      end
      PARIDADE: begin
        conta = 1'b1;
        if (fim_bit) begin
          db_tick = 1'b1;
          desloca = 1'b1;
          proximo = STOP;
        end
      end
      STOP: begin
        conta = 1'b1;
        if (fim_bit) begin
          db_tick = 1'b1;
          desloca = 1'b1;
          proximo = ARMAZENA;
        end
      end
      ARMAZENA: begin
        registra = 1'b1;
        zera     = 1'b1;
        proximo  = INICIAL;
      end
      default: proximo = INICIAL;
    endcase
  end

  assign db_estado = estado;

endmodule

// File: rtl/rx_serial_7e1.sv
// 7E1 asynchronous serial receiver (start, 7 data LSB first, even parity,
// 1 stop) with single-entry holding register and error flags.
// Ports:
//   clock, reset (async, active-low), entrada_serial (RX, idle high)
//   recebe_dado   consumer acknowledge (level)
//   dados_ascii   last character     tem_dado   holding register full
//   pronto        store pulse        erro_paridade/erro_stop/erro_overrun
//   db_tick, db_serial, db_estado    debug
module rx_serial_7e1
  import rx_serial_7e1_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_115200,
  parameter int unsigned CNT_W        = 13
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       entrada_serial,
  input  logic       recebe_dado,
  output logic [6:0] dados_ascii,
  output logic       tem_dado,
  output logic       pronto,
  output logic       erro_paridade,
  output logic       erro_stop,
  output logic       erro_overrun,
  output logic       db_tick,
  output logic       db_serial,
  output logic [3:0] db_estado
);

  logic rx_s, armado, fim_meio, fim_bit, ultimo_dado;
  logic zera, conta, desloca, registra;

  rx_serial_7e1_fd #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CNT_W       (CNT_W)
  ) u_fd (
    .clock         (clock),
    .reset         (reset),
    .entrada_serial(entrada_serial),
    .recebe_dado   (recebe_dado),
    .zera          (zera),
    .conta         (conta),
    .desloca       (desloca),
    .registra      (registra),
    .rx_s          (rx_s),
    .armado        (armado),
    .fim_meio      (fim_meio),
    .fim_bit       (fim_bit),
    .ultimo_dado   (ultimo_dado),
    .dados_ascii   (dados_ascii),
    .tem_dado      (tem_dado),
    .pronto        (pronto),
    .erro_paridade (erro_paridade),
    .erro_stop     (erro_stop),
    .erro_overrun  (erro_overrun)
  );

  rx_serial_7e1_uc u_uc (
    .clock      (clock),
    .reset      (reset),
    .rx_s       (rx_s),
    .armado     (armado),
    .fim_meio   (fim_meio),
    .fim_bit    (fim_bit),
    .ultimo_dado(ultimo_dado),
    .zera       (zera),
    .conta      (conta),
    .desloca    (desloca),
    .registra   (registra),
    .db_tick    (db_tick),
    .db_estado  (db_estado)
  );

  assign db_serial = rx_s;

endmodule
